// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline sequencing controller and the datapath.
// The controller takes the master view; the datapath takes the slave view.
interface pipeline_ctrl_if;
  logic [4:0] d_rs1;
  logic [4:0] d_rs2;
  logic [4:0] e_rd;
  logic       e_memread;
  logic       e_branch_taken;
  logic       m_memreq;
  logic       m_memready;
  logic       halt_req;
  logic       resume;

  logic       f_enable;
  logic       fd_enable;
  logic       fd_clear;
  logic       de_enable;
  logic       de_clear;
  logic       em_enable;
  logic       em_clear;
  logic       mw_enable;
  logic       mw_clear;
  logic       halted;
  logic       mem_timeout;

  modport master (
    input  d_rs1, d_rs2, e_rd, e_memread, e_branch_taken,
           m_memreq, m_memready, halt_req, resume,
    output f_enable, fd_enable, fd_clear, de_enable, de_clear,
           em_enable, em_clear, mw_enable, mw_clear, halted, mem_timeout
  );

  modport slave (
    output d_rs1, d_rs2, e_rd, e_memread, e_branch_taken,
           m_memreq, m_memready, halt_req, resume,
    input  f_enable, fd_enable, fd_clear, de_enable, de_clear,
           em_enable, em_clear, mw_enable, mw_clear, halted, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: hazard stalls, branch flushes, memory wait
// states and a drain-then-halt sequence, all as enable/clear controls.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.master bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [7:0]     WAIT_MAX   = 8'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          stall_mem;
  logic          load_use;

  assign stall_mem = bus.m_memreq & ~bus.m_memready;
  assign load_use  = bus.e_memread & (bus.e_rd != 5'd0) &
                     ((bus.e_rd == bus.d_rs1) | (bus.e_rd == bus.d_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Drain progress is frozen while memory stalls, since no bubble advances.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (bus.halt_req) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!stall_mem) begin
          if (drain_cnt_q == '0) state_d = HALTED;
          else                   drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      HALTED: begin
        if (bus.resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (!stall_mem)                  wait_cnt_d = '0;
    else if (wait_cnt_q == WAIT_MAX) wait_cnt_d = wait_cnt_q;
    else                             wait_cnt_d = wait_cnt_q + 8'd1;
    timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
  end

  // Reset is folded in combinationally so every stage bubbles while it is held.
  always_comb begin
    bus.f_enable  = 1'b1;
    bus.fd_enable = 1'b1;
    bus.fd_clear  = 1'b0;
    bus.de_enable = 1'b1;
    bus.de_clear  = 1'b0;
    bus.em_enable = 1'b1;
    bus.em_clear  = 1'b0;
    bus.mw_enable = 1'b1;
    bus.mw_clear  = 1'b0;
    if (reset) begin
      bus.f_enable  = 1'b0;
      bus.fd_enable = 1'b0;
      bus.fd_clear  = 1'b1;
      bus.de_enable = 1'b0;
      bus.de_clear  = 1'b1;
      bus.em_enable = 1'b0;
      bus.em_clear  = 1'b1;
      bus.mw_enable = 1'b0;
      bus.mw_clear  = 1'b1;
    end else if (state_q == HALTED) begin
      bus.f_enable  = 1'b0;
      bus.fd_enable = 1'b0;
      bus.de_enable = 1'b0;
      bus.em_enable = 1'b0;
      bus.mw_enable = 1'b0;
    end else begin
      if (stall_mem) begin
        bus.f_enable  = 1'b0;
        bus.fd_enable = 1'b0;
        bus.de_enable = 1'b0;
        bus.em_enable = 1'b0;
        bus.mw_enable = 1'b0;
        bus.mw_clear  = 1'b1;
      end else if (bus.e_branch_taken) begin
        bus.fd_clear  = 1'b1;
        bus.de_clear  = 1'b1;
      end else if (load_use) begin
        bus.f_enable  = 1'b0;
        bus.fd_enable = 1'b0;
        bus.de_clear  = 1'b1;
      end
      if (state_q == DRAIN) begin
        bus.f_enable  = 1'b0;
        bus.fd_clear  = 1'b1;
      end
    end
  end

  assign bus.halted      = (state_q == HALTED);
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a cycle-level reference model checked
// every cycle, plus directed scenarios with hand-computed control vectors.
module tb_pipeline_ctrl;
  localparam int DRAIN_N   = 4;
  localparam int TIMEOUT_N = 8;

  // Control vector order: {f_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr}
  localparam logic [8:0] V_RUN    = 9'b110101010;
  localparam logic [8:0] V_LOAD   = 9'b000111010;
  localparam logic [8:0] V_FLUSH  = 9'b111111010;
  localparam logic [8:0] V_STALL  = 9'b000000001;
  localparam logic [8:0] V_DRAIN  = 9'b011101010;
  localparam logic [8:0] V_DSTALL = 9'b001000001;
  localparam logic [8:0] V_HALT   = 9'b000000000;
  localparam logic [8:0] V_RESET  = 9'b001010101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_N), .MEM_TIMEOUT(TIMEOUT_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model: a mode flag pair, remaining drain edges, and stall run length.
  bit mDraining = 1'b0;
  bit mHalted   = 1'b0;
  int mLeft     = 0;
  int mWait     = 0;
  bit mTimeout  = 1'b0;

  wire [8:0] actCtrl = {bus.f_enable, bus.fd_enable, bus.fd_clear, bus.de_enable, bus.de_clear,
                        bus.em_enable, bus.em_clear, bus.mw_enable, bus.mw_clear};

  function automatic logic [8:0] modelCtrl();
    bit fEn, fdEn, fdClr, deEn, deClr, emEn, emClr, mwEn, mwClr;
    bit stall, lu;
    if (reset)   return V_RESET;
    if (mHalted) return V_HALT;
    stall = bus.m_memreq && !bus.m_memready;
    lu    = bus.e_memread && bus.e_rd != 0 && (bus.e_rd == bus.d_rs1 || bus.e_rd == bus.d_rs2);
    {fEn, fdEn, deEn, emEn, mwEn} = 5'b11111;
    {fdClr, deClr, emClr, mwClr}  = 4'b0000;
    if (stall) begin
      {fEn, fdEn, deEn, emEn, mwEn} = 5'b00000;
      mwClr = 1'b1;
    end else if (bus.e_branch_taken) begin
      fdClr = 1'b1;
      deClr = 1'b1;
    end else if (lu) begin
      fEn = 1'b0;
      fdEn = 1'b0;
      deClr = 1'b1;
    end
    if (mDraining) begin
      fEn = 1'b0;
      fdClr = 1'b1;
    end
    return {fEn, fdEn, fdClr, deEn, deClr, emEn, emClr, mwEn, mwClr};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mDraining <= 1'b0;
      mHalted   <= 1'b0;
      mLeft     <= 0;
      mWait     <= 0;
      mTimeout  <= 1'b0;
    end else begin
      if (bus.m_memreq && !bus.m_memready) begin
        mWait <= (mWait + 1 > TIMEOUT_N) ? TIMEOUT_N : mWait + 1;
        if (mWait + 1 >= TIMEOUT_N) mTimeout <= 1'b1;
      end else begin
        mWait <= 0;
      end
      if (mHalted) begin
        if (bus.resume) mHalted <= 1'b0;
      end else if (mDraining) begin
        if (!(bus.m_memreq && !bus.m_memready)) begin
          if (mLeft == 1) begin
            mDraining <= 1'b0;
            mHalted   <= 1'b1;
          end else begin
            mLeft <= mLeft - 1;
          end
        end
      end else if (bus.halt_req) begin
        mDraining <= 1'b1;
        mLeft     <= DRAIN_N;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_ctrl", actCtrl, modelCtrl());
    checkOutput("model_halted", {8'd0, bus.halted}, {8'd0, mHalted});
    checkOutput("model_timeout", {8'd0, bus.mem_timeout}, {8'd0, mTimeout});
  end

  task automatic applyStimulus(input logic memread, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic branch, input logic memreq,
                               input logic memready, input logic haltReq, input logic resumeIn);
    @(posedge clk);
    #1;
    bus.e_memread      = memread;
    bus.e_rd           = rd;
    bus.d_rs1          = rs1;
    bus.d_rs2          = rs2;
    bus.e_branch_taken = branch;
    bus.m_memreq       = memreq;
    bus.m_memready     = memready;
    bus.halt_req       = haltReq;
    bus.resume         = resumeIn;
  endtask

  task automatic idle(input logic haltReq, input logic resumeIn);
    applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, haltReq, resumeIn);
  endtask

  task automatic memStall(input logic branch);
    applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, branch, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expectCycle(input string name, input logic [8:0] ctrl, input logic halted);
    @(negedge clk);
    #1;
    checkOutput({name, "_ctrl"}, actCtrl, ctrl);
    checkOutput({name, "_halted"}, {8'd0, bus.halted}, {8'd0, halted});
  endtask

  initial begin
    bus.e_memread = 1'b0; bus.e_rd = 5'd0; bus.d_rs1 = 5'd0; bus.d_rs2 = 5'd0;
    bus.e_branch_taken = 1'b0; bus.m_memreq = 1'b0; bus.m_memready = 1'b0;
    bus.halt_req = 1'b0; bus.resume = 1'b0;

    expectCycle("reset", V_RESET, 1'b0);
    checkOutput("reset_timeout", {8'd0, bus.mem_timeout}, 9'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    idle(1'b0, 1'b0);                                                  expectCycle("run", V_RUN, 1'b0);
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expectCycle("loaduse_rs1", V_LOAD, 1'b0);
    applyStimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expectCycle("loaduse_rs2", V_LOAD, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expectCycle("loaduse_x0", V_RUN, 1'b0);
    applyStimulus(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expectCycle("no_load", V_RUN, 1'b0);
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); expectCycle("branch_over_lu", V_FLUSH, 1'b0);

    for (int i = 0; i < 3; i++) begin
      memStall(1'b1);
      expectCycle("memwait", V_STALL, 1'b0);
    end
    applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); expectCycle("memwait_flush", V_FLUSH, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("after_wait", V_RUN, 1'b0);

    idle(1'b1, 1'b0);                                                  expectCycle("halt_req", V_RUN, 1'b0);
    for (int i = 0; i < DRAIN_N; i++) begin
      idle(1'b0, 1'b0);
      expectCycle("drain", V_DRAIN, 1'b0);
    end
    idle(1'b0, 1'b0);                                                  expectCycle("halted", V_HALT, 1'b1);
    idle(1'b1, 1'b1);                                                  expectCycle("resume_cycle", V_HALT, 1'b1);
    idle(1'b0, 1'b0);                                                  expectCycle("resumed", V_RUN, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("no_redrain", V_RUN, 1'b0);

    idle(1'b1, 1'b0);                                                  expectCycle("halt_req2", V_RUN, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("drain2_1", V_DRAIN, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("drain2_2", V_DRAIN, 1'b0);
    memStall(1'b0);                                                    expectCycle("drain2_s1", V_DSTALL, 1'b0);
    memStall(1'b0);                                                    expectCycle("drain2_s2", V_DSTALL, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("drain2_3", V_DRAIN, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("drain2_4", V_DRAIN, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("halted2", V_HALT, 1'b1);
    idle(1'b0, 1'b1);                                                  expectCycle("resume2", V_HALT, 1'b1);
    idle(1'b0, 1'b0);                                                  expectCycle("resumed2", V_RUN, 1'b0);

    for (int i = 1; i <= 10; i++) begin
      memStall(1'b0);
      @(negedge clk);
      #1;
      checkOutput("timeout_rise", {8'd0, bus.mem_timeout}, {8'd0, (i > TIMEOUT_N)});
    end
    applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); expectCycle("timeout_ready", V_RUN, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("timeout_idle", V_RUN, 1'b0);
    checkOutput("timeout_sticky", {8'd0, bus.mem_timeout}, 9'd1);

    idle(1'b1, 1'b0);                                                  expectCycle("halt_req3", V_RUN, 1'b0);
    idle(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset_ctrl", actCtrl, V_RESET);
    checkOutput("async_reset_timeout", {8'd0, bus.mem_timeout}, 9'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    idle(1'b0, 1'b0);                                                  expectCycle("post_reset", V_RUN, 1'b0);
    idle(1'b0, 1'b0);                                                  expectCycle("post_reset2", V_RUN, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the five-stage pipeline. Generates `enable` and `clear` for the fetch PC and the IF/ID, ID/EX, EX/DM and DM/WB pipeline registers. It resolves load-use hazards, taken-branch flushes and data-memory wait states, and runs a drain/halt sequence that empties the pipeline on request. It sits beside the datapath and drives no data, only control.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 4: bubble-injection cycles needed to empty IF..WB before halting (≥1).
- `MEM_TIMEOUT`, default 255: maximum consecutive memory-wait cycles before flagging a timeout (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `d_rs1`, `d_rs2`  in  5 each  source registers of the instruction in ID.
- `e_rd`  in  5  destination register of the instruction in EX.
- `e_memread`  in  1  EX instruction is a load.
- `e_branch_taken`  in  1  EX resolved a taken branch or jump.
- `m_memreq`  in  1  DM stage has an active memory access.
- `m_memready`  in  1  memory completes the DM access this cycle.
- `halt_req`  in  1  level request to drain and halt.
- `resume`  in  1  leave the halted state.
- `f_enable`  out  1  PC register enable.
- `fd_enable`, `fd_clear`  out  1 each  IF/ID register controls.
- `de_enable`, `de_clear`  out  1 each  ID/EX register controls.
- `em_enable`, `em_clear`  out  1 each  EX/DM register controls.
- `mw_enable`, `mw_clear`  out  1 each  DM/WB register controls.
- `halted`  out  1  pipeline empty and frozen.
- `mem_timeout`  out  1  sticky memory-timeout flag.

## Operation
- FSM states: RUN, DRAIN, HALTED. There is also a memory-wait counter `wait_cnt` (8 bits, saturating at MEM_TIMEOUT) and a drain counter `drain_cnt`.
- `stall_mem = m_memreq & ~m_memready`. `load_use = e_memread & (e_rd != 0) & (e_rd == d_rs1 | e_rd == d_rs2)`.
- Stage controls are combinational from the state and the inputs. Priority, highest first:
  1. HALTED: all enables 0, all clears 0.
  2. `stall_mem`: f/fd/de/em enables 0, `mw_clear`=1, `mw_enable`=0. The EX branch is held, and its flush is applied when the stall ends.
  3. `e_branch_taken`: all enables 1, `fd_clear`=1, `de_clear`=1. This overrides `load_use`.
  4. `load_use`: `f_enable`=0, `fd_enable`=0, `de_clear`=1, and `em_enable`/`mw_enable`=1.
  5. Default: all enables 1, all clears 0.
- DRAIN: in addition to rows 2–5, `f_enable`=0 and `fd_clear`=1, so bubbles are injected at IF/ID.
- RUN→DRAIN when `halt_req`=1 at a clock edge. This loads `drain_cnt`=DRAIN_CYCLES-1.
- In DRAIN, `drain_cnt` decrements on each edge where `stall_mem`=0 and holds while `stall_mem`=1. At 0 with `stall_mem`=0, the next state is HALTED.
- HALTED→RUN on `resume`=1. `halt_req` must not re-trigger a drain in the same edge; it is re-sampled from RUN onward.
- `halt_req` deasserted during DRAIN does not abort the drain.
- `wait_cnt` increments each edge where `stall_mem`=1 and clears when `stall_mem`=0. When it reaches MEM_TIMEOUT, `mem_timeout` sets and stays set until reset. The stall continues regardless.

## Timing
- Controls have zero latency: hazard inputs in cycle N affect the register edge ending cycle N.
- While `reset`=1: state RUN, both counters 0, `mem_timeout`=0, `halted`=0. All `*_enable` outputs are 0 and all `*_clear` outputs are 1, so every pipeline register is forced to bubble.
- Reset mid-DRAIN or mid-HALTED returns to RUN immediately and asynchronously.
- Drain latency: `halt_req` sampled at edge E gives `halted`=1 after edge E+DRAIN_CYCLES, plus one cycle for each stall cycle in between.
- `halted` is registered, equal to (state==HALTED).
- A `stall_mem` of exactly one cycle produces exactly one bubble at DM/WB. `wait_cnt` returns to 0 on the edge after `m_memready`.

## Test plan
- Load-use: `e_memread`=1, `e_rd`=5, `d_rs1`=5 for 1 cycle -> `f_enable`=0, `fd_enable`=0, `de_clear`=1 that cycle. With `e_rd`=0 and `d_rs1`=0 -> no stall.
- Branch plus load-use in the same cycle: `e_branch_taken`=1 with `load_use` true -> `fd_clear`=1, `de_clear`=1, `f_enable`=1.
- Memory wait: `m_memreq`=1, `m_memready`=0 for 3 cycles with `e_branch_taken`=1 -> f/fd/de/em enables 0 and `mw_clear`=1 for 3 cycles. The flush appears on the 4th cycle, when `m_memready`=1.
- Drain: DRAIN_CYCLES=4, pulse `halt_req` -> `fd_clear`=1 for 4 cycles and `halted`=1 on the 5th. With 2 stall cycles injected mid-drain -> `halted` on the 7th. `resume` -> RUN and all enables 1.
- Timeout: MEM_TIMEOUT=8, hold `stall_mem` for 10 cycles -> `mem_timeout` rises after the 8th stall edge and stays 1 after `m_memready`, until reset.
- Async reset asserted mid-DRAIN, between clock edges -> all clears 1 and enables 0 immediately. After release: `halted`=0, state RUN.
